// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel between the fetch stage and instruction
// memory. The fetch stage drives the request and address; memory returns
// ready and the instruction word.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// and loads the IF/ID register. Handles hazard freeze (with a one-word skid
// buffer) and branch redirects, including redirects that arrive while a
// fetch is still outstanding (DRAIN: address held until memory answers).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              pc_src,
  input  logic [31:0]       branch_addr,
  if_stage_if.master        imem,
  output logic              if_valid,
  output logic [31:0]       instruction,
  output logic [31:0]       pc_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] target_q, target_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4;

  assign pc_plus4       = pc_q + 32'd4;
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q != STALL) && !rst;
  assign if_valid       = valid_q;
  assign instruction    = instr_q;
  assign pc_out         = pc_out_q;

  // Next-state and IF/ID load decisions; priority is pc_src > freeze > fetch.
  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case statement leaves one unassigned (no latches).
    state_d  = state_q;
    pc_d     = pc_q;
    skid_d   = skid_q;
    target_d = target_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;

    unique case (state_q)
      FETCH: begin
        if (pc_src) begin
          valid_d = 1'b0;
          if (imem.imem_ready) begin
            pc_d = branch_addr;
          end else begin
            // Address must stay put until the outstanding fetch completes.
            state_d  = DRAIN;
            target_d = branch_addr;
          end
        end else if (imem.imem_ready) begin
          if (freeze) begin
            skid_d  = imem.imem_rdata;
            state_d = STALL;
          end else begin
            valid_d  = 1'b1;
            instr_d  = imem.imem_rdata;
            pc_out_d = pc_plus4;
            pc_d     = pc_plus4;
          end
        end else if (!freeze) begin
          valid_d = 1'b0;
        end
      end

      STALL: begin
        if (pc_src) begin
          pc_d    = branch_addr;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!freeze) begin
          valid_d  = 1'b1;
          instr_d  = skid_q;
          pc_out_d = pc_plus4;
          pc_d     = pc_plus4;
          state_d  = FETCH;
        end
      end

      DRAIN: begin
        valid_d = 1'b0;
        if (pc_src) begin
          target_d = branch_addr;
        end
        if (imem.imem_ready) begin
          pc_d    = pc_src ? branch_addr : target_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      skid_q   <= 32'd0;
      target_q <= 32'd0;
      valid_q  <= 1'b0;
      instr_q  <= 32'd0;
      pc_out_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      skid_q   <= skid_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// freeze / branch / memory-wait traffic, checked by a scoreboard fed from a
// behavioural fetch model.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        ready = 1'b0;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  int          cycle = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  logic [31:0] cyc_bits;
  assign cyc_bits       = cycle;
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = ready ? mem_word(bus.imem_addr)
                                : (32'hDEAD_0000 | {16'd0, cyc_bits[15:0]});

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .pc_src      (pc_src),
    .branch_addr (branch_addr),
    .imem        (bus.master),
    .if_valid    (if_valid),
    .instruction (instruction),
    .pc_out      (pc_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The program stream: fetch the word at pc, deliver it with pc+4 unless a
  // freeze parks it aside, a branch throws the in-flight fetch away, or a
  // branch arrives before memory answers (then wait, then jump).
  logic        m_init = 1'b0;
  logic [31:0] m_pc;
  logic        m_parked;          // a fetched word waits for the freeze to end
  logic [31:0] m_parked_addr;
  logic        m_redirect;        // a branch waits for the outstanding fetch
  logic [31:0] m_target;
  logic        m_valid;
  logic [31:0] m_last_instr, m_last_pcout;
  logic        m_hold_edge;       // last edge was a freeze hold
  logic [63:0] exp_q[$];

  task automatic deliver(input logic [31:0] addr);
    m_valid      = 1'b1;
    m_last_instr = mem_word(addr);
    m_last_pcout = addr + 32'd4;
    exp_q.push_back({m_last_instr, m_last_pcout});
    m_pc         = addr + 32'd4;
  endtask

  task automatic model_step();
    m_hold_edge = 1'b0;
    if (rst) begin
      m_init       = 1'b1;
      m_pc         = RESET_PC;
      m_parked     = 1'b0;
      m_redirect   = 1'b0;
      m_valid      = 1'b0;
      m_last_instr = 32'd0;
      m_last_pcout = 32'd0;
      exp_q.delete();
    end else if (m_init) begin
      if (m_redirect) begin
        m_valid = 1'b0;
        if (pc_src) m_target = branch_addr;
        if (ready) begin
          m_pc       = m_target;
          m_redirect = 1'b0;
        end
      end else if (m_parked) begin
        if (pc_src) begin
          m_parked = 1'b0;
          m_pc     = branch_addr;
          m_valid  = 1'b0;
        end else if (!freeze) begin
          m_parked = 1'b0;
          deliver(m_parked_addr);
        end else begin
          m_hold_edge = 1'b1;
        end
      end else if (pc_src) begin
        m_valid = 1'b0;
        if (ready) m_pc = branch_addr;
        else begin
          m_redirect = 1'b1;
          m_target   = branch_addr;
        end
      end else if (ready) begin
        if (freeze) begin
          m_parked      = 1'b1;
          m_parked_addr = m_pc;
          m_hold_edge   = 1'b1;
        end else begin
          deliver(m_pc);
        end
      end else if (!freeze) begin
        m_valid = 1'b0;
      end else begin
        m_hold_edge = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      cycle++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic done = 1'b0;
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (m_init && !done) begin
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, !rst && !m_parked});
        check("imem_addr", bus.imem_addr, m_pc);
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        if (if_valid && !rst) begin
          if (!m_hold_edge) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_instr: got %h/%h expected none", instruction, pc_out);
            end else begin
              e = exp_q.pop_front();
              check("instruction", instruction, e[63:32]);
              check("pc_out", pc_out, e[31:0]);
            end
          end else begin
            check("held_instruction", instruction, m_last_instr);
            check("held_pc_out", pc_out, m_last_pcout);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic ps, input logic fz,
                      input logic rdy, input logic [31:0] ba);
    rst         = r;
    pc_src      = ps;
    freeze      = fz;
    ready       = rdy;
    branch_addr = ba;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r, ps, fz, rdy;
    logic [31:0] ba;

    // Reset
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_addr", bus.imem_addr, RESET_PC);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);

    // Zero-wait stream at 0, 4, then a 3-cycle wait at 8
    step(0, 0, 0, 1, 0);
    check("first_instr", instruction, 32'hA5A5_0000);
    check("first_pc_out", pc_out, 32'd4);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    check("wait_addr_stable", bus.imem_addr, 32'd8);
    step(0, 0, 0, 1, 0);
    check("after_wait_pc_out", pc_out, 32'd12);
    step(0, 0, 0, 1, 0);                   // 0x0C

    // Freeze for 4 cycles while 0x10 arrives
    step(0, 0, 1, 1, 0);
    check("stall_req_low", {31'd0, bus.imem_req}, 32'd0);
    check("stall_holds_0c", pc_out, 32'h10);
    repeat (3) step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    check("release_instr", instruction, mem_word(32'h10));
    check("release_pc_out", pc_out, 32'h14);
    repeat (3) step(0, 0, 0, 1, 0);        // 0x14, 0x18, 0x1C

    // Branch to 0x80 while fetch of 0x20 waits 2 cycles
    step(0, 1, 0, 0, 32'h80);
    step(0, 0, 0, 0, 0);
    check("drain_addr_held", bus.imem_addr, 32'h20);
    step(0, 0, 0, 1, 0);
    check("drain_redirect", bus.imem_addr, 32'h80);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Zero-wait branch to 0x40
    step(0, 1, 0, 1, 32'h40);
    check("branch_bubble", {31'd0, if_valid}, 32'd0);
    check("branch_addr", bus.imem_addr, 32'h40);
    step(0, 0, 0, 1, 0);
    check("branch_pc_out", pc_out, 32'h44);

    // PC wrap
    step(0, 1, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0);
    check("wrap_addr", bus.imem_addr, 32'd0);
    check("wrap_pc_out", pc_out, 32'd0);
    step(0, 0, 0, 1, 0);

    // Reset during STALL
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    check("rst_stall_valid", {31'd0, if_valid}, 32'd0);
    check("rst_stall_instr", instruction, 32'd0);
    check("rst_stall_addr", bus.imem_addr, RESET_PC);
    step(0, 0, 0, 1, 0);
    check("restart_instr", instruction, mem_word(RESET_PC));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 249) == 0);
      ps  = ($urandom_range(0, 7) == 0);
      fz  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      ba  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step(r, ps, fz, rdy, ba);
    end
    step(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, issues fetch requests to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register consumed by the decode stage. It sits directly upstream of decode and consumes the branch decision (`pc_src`) and target address that decode's condition-check logic produces. Handles hazard-unit freeze and branch redirect, including redirects that arrive while a fetch is outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock for the block; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `freeze`  in  1  hazard-unit stall; hold IF/ID and the PC.
- `pc_src`  in  1  branch taken, from decode; redirect PC to `branch_addr`.
- `branch_addr`  in  32  branch/jump target, valid when `pc_src`=1.
- `imem_req`  out  1  fetch request, valid for the current `imem_addr`.
- `imem_addr`  out  32  fetch address; always equals the current PC.
- `imem_ready`  in  1  memory response valid this cycle, sampled only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid with `imem_ready`.
- `if_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `instruction`  out  32  IF/ID instruction word.
- `pc_out`  out  32  IF/ID PC+4 of that instruction.

## Operation
- Registered state: `pc`, FSM state, 32-bit skid buffer, and the IF/ID register (`if_valid`, `instruction`, `pc_out`).
- `imem_addr` = `pc`. `imem_req` = 1 in FETCH and DRAIN, 0 in STALL and while `rst`=1.
- PC arithmetic: `pc + 4`, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. `branch_addr` is used as given; bits [1:0] are not checked.
- Priority at each edge: `rst` > `pc_src` > `freeze` > normal fetch.
- FETCH:
  - `pc_src`=1, `imem_ready`=1: discard data, `pc`<=`branch_addr`, `if_valid`<=0, stay FETCH.
  - `pc_src`=1, `imem_ready`=0: `if_valid`<=0. Address must stay stable until ready, so go DRAIN and record `branch_addr` as pending target; `pc` is unchanged.
  - `imem_ready`=1, `freeze`=0: IF/ID <= {1, `imem_rdata`, `pc`+4}; `pc`<=`pc`+4.
  - `imem_ready`=1, `freeze`=1: skid <= `imem_rdata`; IF/ID holds; `pc` holds; go STALL.
  - `imem_ready`=0, `freeze`=0: `if_valid`<=0 (bubble).
  - `imem_ready`=0, `freeze`=1: IF/ID holds.
- STALL (no request):
  - `pc_src`=1: drop skid, `pc`<=`branch_addr`, `if_valid`<=0, go FETCH.
  - `freeze`=0: IF/ID <= {1, skid, `pc`+4}; `pc`<=`pc`+4; go FETCH.
  - Else hold.
- DRAIN:
  - On `imem_ready`: discard data, `pc`<=pending target, go FETCH.
  - `if_valid` stays 0.
  - A new `pc_src` in DRAIN overwrites the pending target.
- Freeze never causes an instruction to be lost or duplicated.

## Timing
- Reset values (edge with `rst`=1): `pc`=`RESET_PC`, state=FETCH, `if_valid`=0, `instruction`=0, `pc_out`=0, skid=0. `imem_req`=0 during the reset cycle and 1 from the first cycle after.
- Latency: response accepted at edge N appears on IF/ID outputs after edge N.
- Zero-wait memory (`imem_ready`=1 in the same cycle as req): one instruction per cycle.
- Branch penalty: `pc_src` at edge N gives `if_valid`=0 after N. With zero wait, `imem_addr`=`branch_addr` in cycle N+1.
- Reset mid-STALL or mid-DRAIN: state abandoned, identical to power-on reset. An outstanding memory response is ignored because `imem_req`=0.

## Test plan
- Reset, `RESET_PC`=0, `imem_ready` tied 1, `imem_rdata`=addr^32'hA5A5_0000 -> `imem_addr` 0,4,8,…; `instruction`/`pc_out` pairs (32'hA5A5_0000,4), (32'hA5A5_0004,8), …; `if_valid`=1 from cycle 2.
- 3-cycle memory wait at addr 8 -> `imem_req`=1 with `imem_addr`=8 stable; 3 bubbles (`if_valid`=0); then instruction for 8 with `pc_out`=12.
- `freeze` high for 4 cycles while the response for 0x10 arrives -> IF/ID holds the 0x0C instruction; `imem_req`=0 in STALL; on release IF/ID = 0x10 instruction, `pc_out`=0x14; no duplicate or missing word.
- `pc_src`=1, `branch_addr`=0x40, zero-wait -> `if_valid`=0 next cycle; `imem_addr`=0x40; then the instruction with `pc_out`=0x44.
- `pc_src`=1, `branch_addr`=0x80, while the fetch of 0x20 is stalled 2 cycles -> `imem_addr` stays 0x20 until ready; data discarded; then `imem_addr`=0x80; `if_valid`=0 throughout the drain.
- PC at 32'hFFFF_FFFC -> next `imem_addr`=0. Assert `rst` during STALL -> all outputs at reset values; fetch restarts at `RESET_PC`.
